// File: rtl/mac_tx_interface_pkg.sv
// Shared definitions for the MAC Tx buffer drain path: header layout, FSM states
// and the last-word byte-enable helper.
package mac_tx_interface_pkg;

    localparam int BC_MSB = 63;
    localparam int BC_LSB = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FIRST,
        ST_WAIT_ACK,
        ST_STREAM,
        ST_COMMIT
    } tx_state_e;

    // Byte enables of the final word of a frame; a zero remainder means a full word.
    function automatic logic [7:0] last_word_mask(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, rem}));
    endfunction

endpackage

// File: rtl/mac_tx_interface_if.sv
// 10G MAC client Tx bus: data, byte enables and the tx_start/tx_ack handshake.
interface mac_tx_interface_if;

    logic [63:0] tx_data;
    logic [7:0]  tx_data_valid;
    logic        tx_start;
    logic        tx_ack;
    logic        tx_underrun;

    modport master (
        output tx_data,
        output tx_data_valid,
        output tx_start,
        output tx_underrun,
        input  tx_ack
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        input  tx_start,
        input  tx_underrun,
        output tx_ack
    );

endinterface

// File: rtl/mac_tx_interface_addr_sync_250.sv
// Brings a committed buffer pointer across from the 250 MHz domain: the qualifier is
// double-flopped and the pointer is only captured while the qualifier says it is stable.
module addr_sync_250 #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] addr_in,
    input  logic         change_in,
    output logic [W-1:0] addr_sync
);

    logic         chg0_q, chg0_d;
    logic         chg1_q, chg1_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        chg0_d = change_in;
        chg1_d = chg0_q;
        addr_d = addr_in;
        sync_d = sync_q;
        if (chg1_q) begin
            sync_d = addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chg0_q <= 1'b0;
            chg1_q <= 1'b0;
            addr_q <= '0;
            sync_q <= '0;
        end else begin
            chg0_q <= chg0_d;
            chg1_q <= chg1_d;
            addr_q <= addr_d;
            sync_q <= sync_d;
        end
    end

    assign addr_sync = sync_q;

endmodule

// File: rtl/mac_tx_interface.sv
// Drains committed frames from the 64-bit Tx packet buffer and streams them to the
// 10G MAC client interface, returning the consumed read pointer to the host side.
module mac_tx_interface
    import mac_tx_interface_pkg::*;
#(
    parameter int AW        = 10,
    parameter int MAX_BYTES = 9600
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [AW-1:0]        rd_addr,
    input  logic [63:0]          rd_data,
    input  logic [AW:0]          commited_wr_address,
    input  logic                 wr_addr_change,
    output logic [AW:0]          commited_rd_address,
    mac_tx_interface_if.master   tx,
    output logic [31:0]          tx_frames_counter,
    output logic [31:0]          dropped_hdr_counter
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]  wr_ptr_sync;
    tx_state_e    state_q, state_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  fetch_q, fetch_d;
    logic [AW:0]  commit_q, commit_d;
    logic [AW:0]  adv_q, adv_d;
    logic [15:0]  words_q, words_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   mask_q, mask_d;
    logic [63:0]  tx_data_q, tx_data_d;
    logic [7:0]   tx_valid_q, tx_valid_d;
    logic         tx_start_q, tx_start_d;
    logic         sent_q, sent_d;
    logic [31:0]  frames_q, frames_d;
    logic [31:0]  drops_q, drops_d;

    logic [31:0]  hdr_bc;
    logic [15:0]  hdr_words;
    logic         hdr_bad;
    logic         pending;
    logic [15:0]  next_cnt;
    logic [7:0]   next_mask;

    addr_sync_250 #(.W(AW+1)) u_wr_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_in   (commited_wr_address),
        .change_in (wr_addr_change),
        .addr_sync (wr_ptr_sync)
    );

    assign pending   = (rd_ptr_q != wr_ptr_sync);
    assign hdr_bc    = rd_data[BC_MSB:BC_LSB];
    // Accepted byte counts fit in 14 bits, so a 16-bit word count is never truncated.
    assign hdr_words = {3'b000, hdr_bc[15:3]} + {15'd0, |hdr_bc[2:0]};
    assign hdr_bad   = (hdr_bc == 32'd0) || (hdr_bc > 32'(MAX_BYTES));
    assign next_cnt  = cnt_q + 16'd1;
    assign next_mask = (next_cnt == words_q) ? mask_q : 8'hFF;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        fetch_d    = fetch_q;
        commit_d   = commit_q;
        adv_d      = adv_q;
        words_d    = words_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_start_d = tx_start_q;
        sent_d     = sent_q;
        frames_d   = frames_q;
        drops_d    = drops_q;

        case (state_q)
            ST_IDLE: begin
                fetch_d = rd_ptr_q;
                if (pending) begin
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                cnt_d = 16'd0;
                if (hdr_bad) begin
                    adv_d   = PTR_ONE;
                    sent_d  = 1'b0;
                    drops_d = drops_q + 32'd1;
                    state_d = ST_COMMIT;
                end else begin
                    words_d = hdr_words;
                    mask_d  = last_word_mask(hdr_bc[2:0]);
                    adv_d   = (AW+1)'(hdr_words) + PTR_ONE;
                    sent_d  = 1'b1;
                    fetch_d = rd_ptr_q + PTR_ONE;
                    state_d = ST_FIRST;
                end
            end

            ST_FIRST: begin
                tx_data_d  = rd_data;
                tx_valid_d = next_mask;
                tx_start_d = 1'b1;
                cnt_d      = next_cnt;
                fetch_d    = fetch_q + PTR_ONE;
                state_d    = ST_WAIT_ACK;
            end

            // After tx_ack the MAC expects every remaining word on consecutive cycles.
            ST_WAIT_ACK, ST_STREAM: begin
                if (state_q == ST_STREAM || tx.tx_ack) begin
                    tx_start_d = 1'b0;
                    if (cnt_q == words_q) begin
                        tx_valid_d = 8'h00;
                        state_d    = ST_COMMIT;
                    end else begin
                        tx_data_d  = rd_data;
                        tx_valid_d = next_mask;
                        cnt_d      = next_cnt;
                        fetch_d    = fetch_q + PTR_ONE;
                        state_d    = ST_STREAM;
                    end
                end
            end

            ST_COMMIT: begin
                rd_ptr_d = rd_ptr_q + adv_q;
                commit_d = rd_ptr_q + adv_q;
                if (sent_q) begin
                    frames_d = frames_q + 32'd1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            fetch_q    <= '0;
            commit_q   <= '0;
            adv_q      <= '0;
            words_q    <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= '0;
            tx_start_q <= 1'b0;
            sent_q     <= 1'b0;
            frames_q   <= '0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            fetch_q    <= fetch_d;
            commit_q   <= commit_d;
            adv_q      <= adv_d;
            words_q    <= words_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_start_q <= tx_start_d;
            sent_q     <= sent_d;
            frames_q   <= frames_d;
            drops_q    <= drops_d;
        end
    end

    assign rd_addr             = fetch_q[AW-1:0];
    assign commited_rd_address = commit_q;
    assign tx_frames_counter   = frames_q;
    assign dropped_hdr_counter = drops_q;
    assign tx.tx_data          = tx_data_q;
    assign tx.tx_data_valid    = tx_valid_q;
    assign tx.tx_start         = tx_start_q;
    assign tx.tx_underrun      = 1'b0;

endmodule

// File: tb/tb_mac_tx_interface.sv
// Bench for mac_tx_interface: a buffer model filled with randomized frames, a MAC-side
// responder, and per-scenario checks against frame expectations derived from the header rules.
module tb_mac_tx_interface;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int PMOD  = 2048;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [AW:0]   commited_wr_address = '0;
    logic          wr_addr_change = 1'b0;
    logic [AW:0]   commited_rd_address;
    logic [31:0]   tx_frames_counter;
    logic [31:0]   dropped_hdr_counter;
    logic [63:0]   mem [DEPTH];

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    mac_tx_interface_if tx_if ();

    mac_tx_interface #(.AW(AW), .MAX_BYTES(9600)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .commited_wr_address (commited_wr_address),
        .wr_addr_change      (wr_addr_change),
        .commited_rd_address (commited_rd_address),
        .tx                  (tx_if),
        .tx_frames_counter   (tx_frames_counter),
        .dropped_hdr_counter (dropped_hdr_counter)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wr_ptr  = 0;
    int exp_frames = 0;
    int exp_drops  = 0;
    int q_hdr[$];
    int q_bc[$];
    int q_end[$];
    logic [63:0] obs_data[$];
    logic [7:0]  obs_valid[$];
    bit          start_stable;

    function automatic int words_of(input int bc);
        return (bc + 7) / 8;
    endfunction

    function automatic logic [7:0] exp_mask(input int bc, input int idx);
        int w;
        int n;
        w = words_of(bc);
        if (idx < w - 1) return 8'hFF;
        n = bc - 8 * (w - 1);
        return 8'((1 << n) - 1);
    endfunction

    task automatic add_frame(input int bc);
        mem[wr_ptr % DEPTH] = {32'(bc), 32'($urandom)};
        for (int i = 1; i <= words_of(bc); i++)
            mem[(wr_ptr + i) % DEPTH] = {32'($urandom), 32'($urandom)};
        q_hdr.push_back(wr_ptr);
        q_bc.push_back(bc);
        wr_ptr = (wr_ptr + 1 + words_of(bc)) % PMOD;
        q_end.push_back(wr_ptr);
    endtask

    task automatic add_bad_header(input logic [31:0] bc);
        mem[wr_ptr % DEPTH] = {bc, 32'($urandom)};
        wr_ptr = (wr_ptr + 1) % PMOD;
    endtask

    task automatic commit_pulse();
        commited_wr_address = (AW+1)'(wr_ptr);
        wr_addr_change = 1'b1;
        repeat (4) @(negedge clk);
        wr_addr_change = 1'b0;
    endtask

    // Acts as the MAC: waits for tx_start, acks after ack_delay cycles, collects the frame.
    task automatic capture_frame(input int ack_delay, output bit got);
        logic [63:0] d0;
        logic [7:0]  v0;
        int t;
        obs_data.delete();
        obs_valid.delete();
        start_stable = 1'b1;
        got = 1'b0;
        t = 0;
        while (tx_if.tx_start !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (tx_if.tx_start !== 1'b1) return;
        got = 1'b1;
        d0 = tx_if.tx_data;
        v0 = tx_if.tx_data_valid;
        repeat (ack_delay) begin
            @(negedge clk);
            if (tx_if.tx_start !== 1'b1 || tx_if.tx_data !== d0 || tx_if.tx_data_valid !== v0)
                start_stable = 1'b0;
        end
        tx_if.tx_ack = 1'b1;
        @(posedge clk);
        #1 tx_if.tx_ack = 1'b0;
        obs_data.push_back(d0);
        obs_valid.push_back(v0);
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (tx_if.tx_start !== 1'b0) start_stable = 1'b0;
            if (tx_if.tx_data_valid === 8'h00) break;
            obs_data.push_back(tx_if.tx_data);
            obs_valid.push_back(tx_if.tx_data_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx_if.tx_data_valid !== 8'h00 || tx_if.tx_start !== 1'b0 || tx_if.tx_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_tx_outputs: valid=%h start=%b data=%h, required 0", tx_if.tx_data_valid, tx_if.tx_start, tx_if.tx_data);
        end
        n_tests++;
        if (rd_addr !== '0 || commited_rd_address !== '0) begin
            n_fail++;
            $display("FAIL reset_addresses: rd_addr=%0d commited_rd=%0d, required 0", rd_addr, commited_rd_address);
        end
        n_tests++;
        if (tx_frames_counter !== 32'd0 || dropped_hdr_counter !== 32'd0 || tx_if.tx_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: frames=%0d drops=%0d underrun=%b, required 0", tx_frames_counter, dropped_hdr_counter, tx_if.tx_underrun);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_frame();
        bit got;
        int h, bc, e, bad;
        add_frame(64);
        commit_pulse();
        capture_frame(0, got);
        h = q_hdr.pop_front(); bc = q_bc.pop_front(); e = q_end.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL full_frame_start: tx_start never rose, required 1");
            return;
        end
        n_tests++;
        if (obs_data.size() != 8) begin
            n_fail++;
            $display("FAIL full_frame_len: %0d words, required 8", obs_data.size());
        end
        bad = 0;
        foreach (obs_data[i])
            if (obs_data[i] !== mem[(h + 1 + i) % DEPTH] || obs_valid[i] !== 8'hFF) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_frame_words: %0d bad words, required 0", bad);
        end
        repeat (2) @(negedge clk);
        exp_frames++;
        n_tests++;
        if (commited_rd_address !== 11'd9 || e != 9) begin
            n_fail++;
            $display("FAIL full_frame_commit: %0d, required 9", commited_rd_address);
        end
        n_tests++;
        if (tx_frames_counter !== 32'(exp_frames)) begin
            n_fail++;
            $display("FAIL full_frame_count: %0d, required %0d", tx_frames_counter, exp_frames);
        end
    endtask

    task automatic test_partial_and_single();
        bit got;
        int e;
        add_frame(61);
        add_frame(8);
        commit_pulse();
        capture_frame(0, got);
        void'(q_hdr.pop_front()); void'(q_bc.pop_front()); void'(q_end.pop_front());
        n_tests++;
        if (!got || obs_valid.size() != 8 || obs_valid[7] !== 8'h1F || obs_valid[6] !== 8'hFF) begin
            n_fail++;
            $display("FAIL partial_last_mask: got=%b words=%0d last=%h, required 8 words last=1f",
                     got, obs_valid.size(), (obs_valid.size() > 0) ? obs_valid[obs_valid.size()-1] : 8'h00);
        end
        exp_frames++;
        capture_frame(0, got);
        void'(q_hdr.pop_front()); void'(q_bc.pop_front()); e = q_end.pop_front();
        n_tests++;
        if (!got || obs_valid.size() != 1 || obs_valid[0] !== 8'hFF) begin
            n_fail++;
            $display("FAIL single_word: got=%b words=%0d, required 1 word with valid ff", got, obs_valid.size());
        end
        exp_frames++;
        repeat (2) @(negedge clk);
        n_tests++;
        if (commited_rd_address !== (AW+1)'(e) || tx_frames_counter !== 32'(exp_frames)) begin
            n_fail++;
            $display("FAIL single_commit: ptr=%0d frames=%0d, required ptr=%0d frames=%0d", commited_rd_address, tx_frames_counter, e, exp_frames);
        end
    endtask

    task automatic test_ack_delay();
        bit got;
        int h, bc, bad;
        add_frame($urandom_range(17, 200));
        commit_pulse();
        capture_frame(20, got);
        h = q_hdr.pop_front(); bc = q_bc.pop_front(); void'(q_end.pop_front());
        n_tests++;
        if (!got || !start_stable) begin
            n_fail++;
            $display("FAIL ack_delay_hold: got=%b stable=%b, required 1/1", got, start_stable);
        end
        bad = (obs_data.size() == words_of(bc)) ? 0 : 1;
        foreach (obs_data[i])
            if (obs_data[i] !== mem[(h + 1 + i) % DEPTH] || obs_valid[i] !== exp_mask(bc, i)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ack_delay_stream: bc=%0d words=%0d bad=%0d, required %0d words bad=0", bc, obs_data.size(), bad, words_of(bc));
        end
        exp_frames++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit got;
        int h, bc, e, bad;
        for (int f = 0; f < 6; f++) add_frame($urandom_range(1, 200));
        commit_pulse();
        for (int f = 0; f < 6; f++) begin
            capture_frame($urandom_range(0, 3), got);
            h = q_hdr.pop_front(); bc = q_bc.pop_front(); e = q_end.pop_front();
            bad = (got && start_stable && obs_data.size() == words_of(bc)) ? 0 : 1;
            foreach (obs_data[i])
                if (obs_data[i] !== mem[(h + 1 + i) % DEPTH] || obs_valid[i] !== exp_mask(bc, i)) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: bc=%0d got=%b words=%0d bad=%0d, required %0d words bad=0", f, bc, got, obs_data.size(), bad, words_of(bc));
            end
            exp_frames++;
            repeat (2) @(negedge clk);
            n_tests++;
            if (commited_rd_address !== (AW+1)'(e) || tx_frames_counter !== 32'(exp_frames)) begin
                n_fail++;
                $display("FAIL b2b_commit%0d: ptr=%0d frames=%0d, required ptr=%0d frames=%0d", f, commited_rd_address, tx_frames_counter, e, exp_frames);
            end
        end
    endtask

    task automatic test_drop();
        bit got;
        int h, bc, e, bad;
        add_bad_header(32'd0);
        add_bad_header(32'd9601);
        add_frame($urandom_range(1, 100));
        commit_pulse();
        capture_frame(1, got);
        h = q_hdr.pop_front(); bc = q_bc.pop_front(); e = q_end.pop_front();
        exp_drops += 2;
        exp_frames++;
        bad = (got && obs_data.size() == words_of(bc)) ? 0 : 1;
        foreach (obs_data[i])
            if (obs_data[i] !== mem[(h + 1 + i) % DEPTH] || obs_valid[i] !== exp_mask(bc, i)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL drop_next_frame: got=%b words=%0d bad=%0d, required %0d words bad=0", got, obs_data.size(), bad, words_of(bc));
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (dropped_hdr_counter !== 32'(exp_drops) || tx_frames_counter !== 32'(exp_frames)) begin
            n_fail++;
            $display("FAIL drop_counters: drops=%0d frames=%0d, required %0d/%0d", dropped_hdr_counter, tx_frames_counter, exp_drops, exp_frames);
        end
        n_tests++;
        if (commited_rd_address !== (AW+1)'(e)) begin
            n_fail++;
            $display("FAIL drop_commit: %0d, required %0d", commited_rd_address, e);
        end
    endtask

    task automatic test_wrap();
        bit got;
        int h, bc, e, bad;
        add_frame(8 * (1020 - wr_ptr - 1));
        add_frame(64);
        commit_pulse();
        for (int f = 0; f < 2; f++) begin
            capture_frame(0, got);
            h = q_hdr.pop_front(); bc = q_bc.pop_front(); e = q_end.pop_front();
            exp_frames++;
            bad = (got && obs_data.size() == words_of(bc)) ? 0 : 1;
            foreach (obs_data[i])
                if (obs_data[i] !== mem[(h + 1 + i) % DEPTH] || obs_valid[i] !== exp_mask(bc, i)) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL wrap_frame%0d: hdr=%0d words=%0d bad=%0d, required %0d words bad=0", f, h, obs_data.size(), bad, words_of(bc));
            end
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (commited_rd_address !== 11'd1029 || h != 1020) begin
            n_fail++;
            $display("FAIL wrap_commit: %0d (hdr %0d), required 1029 (hdr 1020)", commited_rd_address, h);
        end
    endtask

    task automatic test_reset_midframe();
        bit got;
        bit saw_start;
        int h, bc, e, bad, t;
        add_frame(400);
        commit_pulse();
        t = 0;
        while (tx_if.tx_start !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        tx_if.tx_ack = 1'b1;
        @(posedge clk);
        #1 tx_if.tx_ack = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (tx_if.tx_data_valid !== 8'hFF) begin
            n_fail++;
            $display("FAIL midframe_streaming: valid=%h, required ff", tx_if.tx_data_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (tx_if.tx_data_valid !== 8'h00 || tx_if.tx_start !== 1'b0 || commited_rd_address !== '0 || tx_frames_counter !== 32'd0) begin
            n_fail++;
            $display("FAIL midframe_async_reset: valid=%h start=%b ptr=%0d frames=%0d, required all 0",
                     tx_if.tx_data_valid, tx_if.tx_start, commited_rd_address, tx_frames_counter);
        end
        q_hdr.delete(); q_bc.delete(); q_end.delete();
        wr_ptr = 0; exp_frames = 0; exp_drops = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_start = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx_if.tx_start !== 1'b0 || tx_if.tx_data_valid !== 8'h00) saw_start = 1'b1;
        end
        n_tests++;
        if (saw_start) begin
            n_fail++;
            $display("FAIL post_reset_quiet: activity seen before a new change pulse, required none");
        end
        add_frame($urandom_range(9, 120));
        commit_pulse();
        capture_frame(2, got);
        h = q_hdr.pop_front(); bc = q_bc.pop_front(); e = q_end.pop_front();
        exp_frames++;
        bad = (got && obs_data.size() == words_of(bc)) ? 0 : 1;
        foreach (obs_data[i])
            if (obs_data[i] !== mem[(h + 1 + i) % DEPTH] || obs_valid[i] !== exp_mask(bc, i)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_frame: words=%0d bad=%0d, required %0d words bad=0", obs_data.size(), bad, words_of(bc));
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (commited_rd_address !== (AW+1)'(e) || tx_frames_counter !== 32'(exp_frames)) begin
            n_fail++;
            $display("FAIL post_reset_commit: ptr=%0d frames=%0d, required ptr=%0d frames=%0d", commited_rd_address, tx_frames_counter, e, exp_frames);
        end
    endtask

    initial begin
        tx_if.tx_ack = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        test_reset();
        test_full_frame();
        test_partial_and_single();
        test_ack_delay();
        test_back_to_back();
        test_drop();
        test_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
